// File: rtl/sd_dma.sv
// sd_dma: SD byte FIFOs <-> 16-bit memory DMA; define SD_DMA_BYTE_SWAP_EN for little-endian lane packing
module sd_dma #(
  parameter int ADDR_W = 27,
  parameter int LEN_W = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              direction,
  input  logic [ADDR_W-1:0] start_address,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  input  logic              rx_empty,
  output logic              rx_read,
  input  logic [7:0]        rx_rdata,
  input  logic              tx_full,
  output logic              tx_write,
  output logic [7:0]        tx_wdata,
  output logic              mem_request,
  input  logic              mem_ack,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0]        mem_wmask,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata
);
`ifdef SD_DMA_BYTE_SWAP_EN
  localparam logic SWAP = 1'b1;
`else
  localparam logic SWAP = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, RX_FETCH, RX_WAIT, MEM_WRITE, MEM_READ, TX_PUSH, ABORT} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0] wmask_q, wmask_d;
  logic dir_q, dir_d, done_q, done_d;
  logic hi, last;
  assign hi = ptr_q[0] == SWAP;
  assign last = rem_q == LEN_W'(1);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    addr_d = addr_q;
    rem_d = rem_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wmask_d = wmask_q;
    dir_d = dir_q;
    done_d = 1'b0;
    rx_read = 1'b0;
    tx_write = 1'b0;
    case (state_q)
      IDLE: if (start && !stop) begin
        ptr_d = start_address;
        addr_d = {start_address[ADDR_W-1:1], 1'b0};
        rem_d = length;
        dir_d = direction;
        wmask_d = 2'b00;
        done_d = length == '0;
        state_d = length == '0 ? IDLE : direction ? MEM_READ : RX_FETCH;
      end
      RX_FETCH: if (stop) state_d = IDLE;
      else if (!rx_empty) begin
        rx_read = 1'b1;
        state_d = RX_WAIT;
      end
      RX_WAIT: if (stop) state_d = IDLE;
      else begin
        wdata_d = hi ? {rx_rdata, wdata_q[7:0]} : {wdata_q[15:8], rx_rdata};
        wmask_d = wmask_q | (hi ? 2'b10 : 2'b01);
        addr_d = {ptr_q[ADDR_W-1:1], 1'b0};
        ptr_d = ptr_q + ADDR_W'(1);
        rem_d = rem_q - LEN_W'(1);
        state_d = (ptr_q[0] || last) ? MEM_WRITE : RX_FETCH;
      end
      MEM_WRITE: if (stop) state_d = mem_ack ? IDLE : ABORT;
      else if (mem_ack) begin
        wmask_d = 2'b00;
        done_d = rem_q == '0;
        state_d = rem_q == '0 ? IDLE : RX_FETCH;
      end
      MEM_READ: if (stop) state_d = mem_ack ? IDLE : ABORT;
      else if (mem_ack) begin
        rdata_d = mem_rdata;
        state_d = TX_PUSH;
      end
      TX_PUSH: if (stop) state_d = IDLE;
      else if (!tx_full) begin
        tx_write = 1'b1;
        ptr_d = ptr_q + ADDR_W'(1);
        addr_d = {ptr_d[ADDR_W-1:1], 1'b0};
        rem_d = rem_q - LEN_W'(1);
        done_d = last;
        state_d = last ? IDLE : ptr_q[0] ? MEM_READ : TX_PUSH;
      end
      ABORT: state_d = mem_ack ? IDLE : ABORT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      addr_q <= '0;
      rem_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wmask_q <= '0;
      dir_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wmask_q <= wmask_d;
      dir_q <= dir_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign mem_request = state_q == MEM_WRITE || state_q == MEM_READ || state_q == ABORT;
  assign mem_write = state_q == MEM_WRITE || (state_q == ABORT && !dir_q);
  assign mem_address = addr_q;
  assign mem_wmask = wmask_q;
  assign mem_wdata = wdata_q;
  assign tx_wdata = hi ? rdata_q[15:8] : rdata_q[7:0];
endmodule
